// File: rtl/hdma_ctrl.sv
// CGB HDMA register front-end (FF51-FF55).
// Holds the CPU-visible HDMA registers and the block pointers, and
// sequences general-purpose and HBlank DMA bursts into the DMA engine.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no transfer pending; pointer and FF55 writes accepted
// GDMA_RUN  | one general-purpose burst in flight; CPU stalled
// HDMA_WAIT | HBlank DMA armed, waiting for the next hblank_start
// HDMA_RUN  | one 16-byte HBlank block in flight; CPU stalled
module hdma_ctrl #(
   parameter logic [15:0] REG_BASE = 16'hFF51
) (
   input  logic        clk4_2,
   input  logic        reset_n,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_wr_en,
   output logic [7:0]  cpu_data_out,
   input  logic        hblank_start,
   input  logic        GDMA_finished,
   output logic [7:0]  HDMA1,
   output logic [7:0]  HDMA2,
   output logic [7:0]  HDMA3,
   output logic [7:0]  HDMA4,
   output logic [7:0]  HDMA5,
   output logic        DMA_start,
   output logic        cpu_stall,
   output logic        hdma_active
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GDMA_RUN  = 2'd1,
      HDMA_WAIT = 2'd2,
      HDMA_RUN  = 2'd3
   } state_t;

   state_t      r_state;
   logic [11:0] r_src_ptr;    // source[15:4]
   logic [8:0]  r_dst_ptr;    // dest[12:4]
   logic [6:0]  r_remaining;  // blocks left minus one
   logic [7:0]  r_status;
   logic [7:0]  r_hdma5;
   logic        r_dma_start;
   logic        r_cpu_stall;

   logic        w_wr_hdma1;
   logic        w_wr_hdma2;
   logic        w_wr_hdma3;
   logic        w_wr_hdma4;
   logic        w_wr_hdma5;
   logic        w_sel_hdma5;
   logic        w_ptr_wr_ok;
   logic [11:0] w_src_burst;
   logic [8:0]  w_dst_burst;

   // Address decode of the five HDMA registers
   always_comb begin
      w_sel_hdma5 = (cpu_addr == REG_BASE + 16'd4);
      w_wr_hdma1  = cpu_wr_en && (cpu_addr == REG_BASE);
      w_wr_hdma2  = cpu_wr_en && (cpu_addr == REG_BASE + 16'd1);
      w_wr_hdma3  = cpu_wr_en && (cpu_addr == REG_BASE + 16'd2);
      w_wr_hdma4  = cpu_wr_en && (cpu_addr == REG_BASE + 16'd3);
      w_wr_hdma5  = cpu_wr_en && w_sel_hdma5;
      // Pointers may only change while the engine is not using them
      w_ptr_wr_ok = (r_state == IDLE) || (r_state == HDMA_WAIT);
      // A general-purpose burst moves remaining+1 blocks
      w_src_burst = r_src_ptr + {5'd0, r_remaining} + 12'd1;
      w_dst_burst = r_dst_ptr + {2'd0, r_remaining} + 9'd1;
   end

   // Only FF55 is readable; everything else reads as open bus
   assign cpu_data_out = w_sel_hdma5 ? r_status : 8'hFF;

   assign HDMA1       = r_src_ptr[11:4];
   assign HDMA2       = {r_src_ptr[3:0], 4'h0};
   assign HDMA3       = {3'b000, r_dst_ptr[8:4]};
   assign HDMA4       = {r_dst_ptr[3:0], 4'h0};
   assign HDMA5       = r_hdma5;
   assign DMA_start   = r_dma_start;
   assign cpu_stall   = r_cpu_stall;
   assign hdma_active = (r_state == HDMA_WAIT) || (r_state == HDMA_RUN);

   // Transfer sequencer, register file and pointer tracking
   always_ff @(posedge clk4_2 or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_src_ptr   <= 12'd0;
         r_dst_ptr   <= 9'd0;
         r_remaining <= 7'h7F;
         r_status    <= 8'hFF;
         r_hdma5     <= 8'h00;
         r_dma_start <= 1'b0;
         r_cpu_stall <= 1'b0;
      end else begin
         r_dma_start <= 1'b0;

         if (w_ptr_wr_ok) begin
            if (w_wr_hdma1) r_src_ptr[11:4] <= cpu_data_in;
            if (w_wr_hdma2) r_src_ptr[3:0]  <= cpu_data_in[7:4];
            if (w_wr_hdma3) r_dst_ptr[8:4]  <= cpu_data_in[4:0];
            if (w_wr_hdma4) r_dst_ptr[3:0]  <= cpu_data_in[7:4];
         end

         case (r_state)
            IDLE: begin
               if (w_wr_hdma5) begin
                  r_remaining <= cpu_data_in[6:0];
                  if (!cpu_data_in[7]) begin
                     r_state     <= GDMA_RUN;
                     r_hdma5     <= {1'b0, cpu_data_in[6:0]};
                     r_dma_start <= 1'b1;
                     r_cpu_stall <= 1'b1;
                  end else begin
                     r_state  <= HDMA_WAIT;
                     r_status <= {1'b0, cpu_data_in[6:0]};
                  end
               end
            end

            GDMA_RUN: begin
               if (GDMA_finished) begin
                  r_state     <= IDLE;
                  r_src_ptr   <= w_src_burst;
                  r_dst_ptr   <= w_dst_burst;
                  r_status    <= 8'hFF;
                  r_cpu_stall <= 1'b0;
               end
            end

            HDMA_WAIT: begin
               // A CPU write to FF55 takes priority over a coincident HBlank
               if (w_wr_hdma5) begin
                  if (cpu_data_in[7]) begin
                     r_remaining <= cpu_data_in[6:0];
                     r_status    <= {1'b0, cpu_data_in[6:0]};
                  end else begin
                     r_state  <= IDLE;
                     r_status <= {1'b1, r_remaining};
                  end
               end else if (hblank_start) begin
                  r_state     <= HDMA_RUN;
                  r_hdma5     <= 8'h00;
                  r_dma_start <= 1'b1;
                  r_cpu_stall <= 1'b1;
               end
            end

            HDMA_RUN: begin
               if (GDMA_finished) begin
                  r_src_ptr   <= r_src_ptr + 12'd1;
                  r_dst_ptr   <= r_dst_ptr + 9'd1;
                  r_cpu_stall <= 1'b0;
                  if (r_remaining == 7'd0) begin
                     r_state  <= IDLE;
                     r_status <= 8'hFF;
                  end else begin
                     r_state     <= HDMA_WAIT;
                     r_remaining <= r_remaining - 7'd1;
                     r_status    <= {1'b0, r_remaining - 7'd1};
                  end
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hdma_ctrl.sv
// Directed bench for hdma_ctrl: GDMA, HBlank DMA, cancel, restart,
// write/HBlank collision, pointer wrap and asynchronous reset.
module tb_hdma_ctrl;

   logic        clk4_2 = 1'b0;
   logic        reset_n;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_in;
   logic        cpu_wr_en;
   logic [7:0]  cpu_data_out;
   logic        hblank_start;
   logic        GDMA_finished;
   logic [7:0]  HDMA1, HDMA2, HDMA3, HDMA4, HDMA5;
   logic        DMA_start;
   logic        cpu_stall;
   logic        hdma_active;

   int errors = 0;
   int checks = 0;

   hdma_ctrl #(.REG_BASE(16'hFF51)) dut (
      .clk4_2        (clk4_2),
      .reset_n       (reset_n),
      .cpu_addr      (cpu_addr),
      .cpu_data_in   (cpu_data_in),
      .cpu_wr_en     (cpu_wr_en),
      .cpu_data_out  (cpu_data_out),
      .hblank_start  (hblank_start),
      .GDMA_finished (GDMA_finished),
      .HDMA1         (HDMA1),
      .HDMA2         (HDMA2),
      .HDMA3         (HDMA3),
      .HDMA4         (HDMA4),
      .HDMA5         (HDMA5),
      .DMA_start     (DMA_start),
      .cpu_stall     (cpu_stall),
      .hdma_active   (hdma_active)
   );

   always #5 clk4_2 = ~clk4_2;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
      cpu_addr = addr;
      #1;
      chk(tag, cpu_data_out, exp);
   endtask

   task automatic wr(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clk4_2);
      cpu_addr    = addr;
      cpu_data_in = data;
      cpu_wr_en   = 1'b1;
      @(negedge clk4_2);
      cpu_wr_en   = 1'b0;
   endtask

   task automatic hblank();
      @(negedge clk4_2);
      hblank_start = 1'b1;
      @(negedge clk4_2);
      hblank_start = 1'b0;
   endtask

   task automatic finish_pulse();
      @(negedge clk4_2);
      GDMA_finished = 1'b1;
      @(negedge clk4_2);
      GDMA_finished = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk4_2);
      reset_n = 1'b0;
      @(negedge clk4_2);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n       = 1'b0;
      cpu_addr      = 16'h0000;
      cpu_data_in   = 8'h00;
      cpu_wr_en     = 1'b0;
      hblank_start  = 1'b0;
      GDMA_finished = 1'b0;
      repeat (2) @(negedge clk4_2);

      // Reset state
      chk("rst_hdma1", HDMA1, 8'h00);
      chk("rst_hdma5", HDMA5, 8'h00);
      chk("rst_start", {7'd0, DMA_start}, 8'h00);
      chk("rst_stall", {7'd0, cpu_stall}, 8'h00);
      chk("rst_active", {7'd0, hdma_active}, 8'h00);
      rd("rst_ff55", 16'hFF55, 8'hFF);
      reset_n = 1'b1;
      rd("rd_ff51", 16'hFF51, 8'hFF);
      rd("rd_other", 16'h1234, 8'hFF);

      // General-purpose DMA: 4 blocks from C000 to 8000
      wr(16'hFF51, 8'hC0);
      wr(16'hFF52, 8'h00);
      wr(16'hFF53, 8'h00);
      wr(16'hFF54, 8'h00);
      wr(16'hFF55, 8'h03);
      chk("gdma_start", {7'd0, DMA_start}, 8'h01);
      chk("gdma_hdma5", HDMA5, 8'h03);
      chk("gdma_stall", {7'd0, cpu_stall}, 8'h01);
      @(negedge clk4_2);
      chk("gdma_start_1cyc", {7'd0, DMA_start}, 8'h00);
      chk("gdma_stall_hold", {7'd0, cpu_stall}, 8'h01);
      finish_pulse();
      chk("gdma_unstall", {7'd0, cpu_stall}, 8'h00);
      chk("gdma_hdma1", HDMA1, 8'hC0);
      chk("gdma_hdma2", HDMA2, 8'h40);
      chk("gdma_hdma3", HDMA3, 8'h00);
      chk("gdma_hdma4", HDMA4, 8'h40);
      chk("gdma_hdma5_hold", HDMA5, 8'h03);
      rd("gdma_ff55", 16'hFF55, 8'hFF);

      // HBlank DMA: 2 blocks from zeroed pointers
      do_reset();
      wr(16'hFF55, 8'h81);
      chk("hdma_nostart", {7'd0, DMA_start}, 8'h00);
      chk("hdma_active", {7'd0, hdma_active}, 8'h01);
      rd("hdma_ff55_a", 16'hFF55, 8'h01);
      hblank();
      chk("hdma_start1", {7'd0, DMA_start}, 8'h01);
      chk("hdma_hdma5", HDMA5, 8'h00);
      chk("hdma_stall1", {7'd0, cpu_stall}, 8'h01);
      hblank();
      chk("hdma_run_hblank_ign", {7'd0, DMA_start}, 8'h00);
      finish_pulse();
      chk("hdma_unstall1", {7'd0, cpu_stall}, 8'h00);
      rd("hdma_ff55_b", 16'hFF55, 8'h00);
      chk("hdma_hdma2_b", HDMA2, 8'h10);
      chk("hdma_hdma4_b", HDMA4, 8'h10);
      chk("hdma_active_b", {7'd0, hdma_active}, 8'h01);
      hblank();
      chk("hdma_start2", {7'd0, DMA_start}, 8'h01);
      finish_pulse();
      rd("hdma_ff55_c", 16'hFF55, 8'hFF);
      chk("hdma_active_c", {7'd0, hdma_active}, 8'h00);
      chk("hdma_hdma2_c", HDMA2, 8'h20);
      hblank();
      chk("hdma_idle_hblank", {7'd0, DMA_start}, 8'h00);
      chk("hdma_idle_stall", {7'd0, cpu_stall}, 8'h00);

      // Cancel after one of six blocks
      do_reset();
      wr(16'hFF55, 8'h85);
      hblank();
      finish_pulse();
      rd("cancel_pre", 16'hFF55, 8'h04);
      wr(16'hFF55, 8'h00);
      rd("cancel_ff55", 16'hFF55, 8'h84);
      chk("cancel_active", {7'd0, hdma_active}, 8'h00);
      hblank();
      chk("cancel_nostart", {7'd0, DMA_start}, 8'h00);

      // Cancel and HBlank in the same cycle: cancel wins
      wr(16'hFF55, 8'h83);
      @(negedge clk4_2);
      cpu_addr     = 16'hFF55;
      cpu_data_in  = 8'h00;
      cpu_wr_en    = 1'b1;
      hblank_start = 1'b1;
      @(negedge clk4_2);
      cpu_wr_en    = 1'b0;
      hblank_start = 1'b0;
      chk("coll_nostart", {7'd0, DMA_start}, 8'h00);
      chk("coll_nostall", {7'd0, cpu_stall}, 8'h00);
      chk("coll_active", {7'd0, hdma_active}, 8'h00);
      rd("coll_ff55", 16'hFF55, 8'h83);

      // Restart while armed, then cancel
      wr(16'hFF55, 8'h82);
      rd("restart_a", 16'hFF55, 8'h02);
      wr(16'hFF55, 8'h85);
      rd("restart_b", 16'hFF55, 8'h05);
      wr(16'hFF55, 8'h00);
      rd("restart_cancel", 16'hFF55, 8'h85);

      // Pointer wrap on a 2-block GDMA from FFF0 to 1FF0
      do_reset();
      wr(16'hFF51, 8'hFF);
      wr(16'hFF52, 8'hF7);
      wr(16'hFF53, 8'hFF);
      wr(16'hFF54, 8'hF3);
      chk("wrap_pre_hdma2", HDMA2, 8'hF0);
      chk("wrap_pre_hdma3", HDMA3, 8'h1F);
      wr(16'hFF55, 8'h01);
      chk("wrap_hdma5", HDMA5, 8'h01);
      finish_pulse();
      chk("wrap_hdma1", HDMA1, 8'h00);
      chk("wrap_hdma2", HDMA2, 8'h10);
      chk("wrap_hdma3", HDMA3, 8'h00);
      chk("wrap_hdma4", HDMA4, 8'h10);

      // Asynchronous reset in the middle of a GDMA burst
      wr(16'hFF51, 8'hAB);
      wr(16'hFF55, 8'h07);
      chk("mid_stall", {7'd0, cpu_stall}, 8'h01);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_start", {7'd0, DMA_start}, 8'h00);
      chk("mid_rst_stall", {7'd0, cpu_stall}, 8'h00);
      chk("mid_rst_hdma1", HDMA1, 8'h00);
      chk("mid_rst_hdma5", HDMA5, 8'h00);
      chk("mid_rst_active", {7'd0, hdma_active}, 8'h00);
      @(negedge clk4_2);
      reset_n = 1'b1;
      finish_pulse();
      chk("late_fin_stall", {7'd0, cpu_stall}, 8'h00);
      chk("late_fin_hdma1", HDMA1, 8'h00);
      chk("late_fin_hdma2", HDMA2, 8'h00);
      rd("late_fin_ff55", 16'hFF55, 8'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
